// File: rtl/cordic_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cordic_pkg
//  Purpose  : Shared types and constants for the CORDIC reduce sequencer:
//             FSM state encoding, FP word constants, default data width.
//  Revision : 1.0  initial release
// ============================================================================
package cordic_pkg;

    localparam int CORDIC_DATA_W = 32;

    localparam logic [31:0] FP_ZERO = 32'h0000_0000;
    localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        LAUNCH      = 3'd1,
        WAIT_LANES  = 3'd2,
        REDUCE_INIT = 3'd3,
        ADD_ISSUE   = 3'd4,
        ADD_WAIT    = 3'd5,
        FINISH      = 3'd6
    } state_t;

endpackage
`default_nettype wire

// File: rtl/lane_collect.sv
`default_nettype none
// ============================================================================
//  Module   : lane_collect
//  Purpose  : Per-lane result capture. Each lane's first completion pulse
//             while capture is enabled latches its result and sets its mask
//             bit; repeat pulses are ignored. o_all_done looks ahead so the
//             controller can leave the wait state on the completing edge.
//  Revision : 1.0  initial release
// ============================================================================
module lane_collect
    import cordic_pkg::*;
#(
    parameter int NUM_LANES = 4,
    parameter int DATA_W    = CORDIC_DATA_W
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 i_clear,
    input  logic                                 i_capture_en,
    input  logic [NUM_LANES-1:0]                 i_lane_done,
    input  logic [NUM_LANES*DATA_W-1:0]          i_lane_result,
    output logic [NUM_LANES-1:0][DATA_W-1:0]     o_slots,
    output logic                                 o_all_done
);

    logic [NUM_LANES-1:0]              r_mask;
    logic [NUM_LANES-1:0][DATA_W-1:0]  r_slots;
    logic [NUM_LANES-1:0]              w_take;

    // A lane is taken only on its first pulse and only while capturing.
    assign w_take     = i_lane_done & ~r_mask & {NUM_LANES{i_capture_en}};
    assign o_all_done = i_capture_en & (&(r_mask | w_take));
    assign o_slots    = r_slots;

    // Done mask: cleared when a new operation is accepted, accumulates lanes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mask <= '0;
        end else if (i_clear) begin
            r_mask <= '0;
        end else begin
            r_mask <= r_mask | w_take;
        end
    end

    // Result slots: latch each lane's result on its accepted pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_slots <= '0;
        end else begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (w_take[i]) begin
                    r_slots[i] <= i_lane_result[i*DATA_W +: DATA_W];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/cordic_reduce_seq.sv
`default_nettype none
// ============================================================================
//  Module   : cordic_reduce_seq
//  Purpose  : Launches NUM_LANES external CORDIC lanes, collects their
//             results, reduces them serially through one external FP adder,
//             optionally accumulates across calls, and aborts on timeout.
//  Revision : 1.0  initial release
// ============================================================================
module cordic_reduce_seq
    import cordic_pkg::*;
#(
    parameter int                NUM_LANES      = 4,
    parameter int                DATA_W         = CORDIC_DATA_W,
    parameter int                TIMEOUT_CYCLES = 1024,
    parameter logic [DATA_W-1:0] NAN_WORD       = FP_QNAN
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          i_start,
    input  logic                          i_acc_mode,
    input  logic                          i_acc_clear,
    input  logic [NUM_LANES*DATA_W-1:0]   i_data_in,
    output logic [NUM_LANES*DATA_W-1:0]   o_lane_data,
    output logic [NUM_LANES-1:0]          o_lane_start,
    input  logic [NUM_LANES-1:0]          i_lane_done,
    input  logic [NUM_LANES*DATA_W-1:0]   i_lane_result,
    output logic [DATA_W-1:0]             o_add_dataa,
    output logic [DATA_W-1:0]             o_add_datab,
    output logic                          o_add_enable,
    input  logic                          i_add_done,
    input  logic [DATA_W-1:0]             i_add_result,
    output logic [DATA_W-1:0]             o_result,
    output logic                          o_done,
    output logic                          o_error,
    output logic                          o_busy
);

    localparam int IDX_W = $clog2(NUM_LANES + 1);
    localparam int SEL_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    state_t                            r_state;
    state_t                            w_state_nxt;
    logic [NUM_LANES*DATA_W-1:0]       r_lane_data;
    logic                              r_acc_mode;
    logic [DATA_W-1:0]                 r_acc;
    logic [DATA_W-1:0]                 r_sum;
    logic [IDX_W-1:0]                  r_idx;
    logic [DATA_W-1:0]                 r_result;
    logic                              r_done;
    logic                              r_error;
    logic [TMO_W-1:0]                  r_tmo;

    logic [DATA_W-1:0]                 w_sum_nxt;
    logic [IDX_W-1:0]                  w_idx_nxt;
    logic                              w_accept;
    logic                              w_finish;
    logic                              w_abort;
    logic                              w_lane_start;
    logic                              w_add_enable;
    logic                              w_tmo_hit;
    logic                              w_waiting;
    logic [SEL_W-1:0]                  w_idx_sel;
    logic [NUM_LANES-1:0][DATA_W-1:0]  w_slots;
    logic                              w_all_done;

    lane_collect #(
        .NUM_LANES (NUM_LANES),
        .DATA_W    (DATA_W)
    ) u_lane_collect (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_clear       (w_accept),
        .i_capture_en  (r_state == WAIT_LANES),
        .i_lane_done   (i_lane_done),
        .i_lane_result (i_lane_result),
        .o_slots       (w_slots),
        .o_all_done    (w_all_done)
    );

    assign w_waiting = (r_state == WAIT_LANES) || (r_state == ADD_WAIT);
    assign w_tmo_hit = (r_tmo == TMO_W'(TIMEOUT_CYCLES - 1));
    // Index past the last lane only occurs when no add is pending; clamp it.
    assign w_idx_sel = (r_idx < IDX_W'(NUM_LANES)) ? SEL_W'(r_idx) : '0;

    assign o_lane_data  = r_lane_data;
    assign o_lane_start = {NUM_LANES{w_lane_start}};
    assign o_add_enable = w_add_enable;
    // Operands come straight from held registers, so they stay stable
    // from the issue cycle until the adder answers.
    assign o_add_dataa  = r_sum;
    assign o_add_datab  = w_slots[w_idx_sel];
    assign o_result     = r_result;
    assign o_done       = r_done;
    assign o_error      = r_error;
    assign o_busy       = (r_state != IDLE);

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, strobes and next reduction sum/index.
    always_comb begin
        w_state_nxt  = r_state;
        w_sum_nxt    = r_sum;
        w_idx_nxt    = r_idx;
        w_accept     = 1'b0;
        w_finish     = 1'b0;
        w_abort      = 1'b0;
        w_lane_start = 1'b0;
        w_add_enable = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = LAUNCH;
                end
            end
            LAUNCH: begin
                w_lane_start = 1'b1;
                w_state_nxt  = WAIT_LANES;
            end
            WAIT_LANES: begin
                if (w_all_done) begin
                    w_state_nxt = REDUCE_INIT;
                end else if (w_tmo_hit) begin
                    w_abort     = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            REDUCE_INIT: begin
                if (r_acc_mode) begin
                    w_sum_nxt = r_acc;
                    w_idx_nxt = '0;
                end else begin
                    w_sum_nxt = w_slots[0];
                    w_idx_nxt = IDX_W'(1);
                end
                if (w_idx_nxt == IDX_W'(NUM_LANES)) begin
                    w_finish    = 1'b1;
                    w_state_nxt = FINISH;
                end else begin
                    w_state_nxt = ADD_ISSUE;
                end
            end
            ADD_ISSUE: begin
                w_add_enable = 1'b1;
                w_state_nxt  = ADD_WAIT;
            end
            ADD_WAIT: begin
                if (i_add_done) begin
                    w_sum_nxt = i_add_result;
                    w_idx_nxt = r_idx + IDX_W'(1);
                    if (w_idx_nxt == IDX_W'(NUM_LANES)) begin
                        w_finish    = 1'b1;
                        w_state_nxt = FINISH;
                    end else begin
                        w_state_nxt = ADD_ISSUE;
                    end
                end else if (w_tmo_hit) begin
                    w_abort     = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            FINISH: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Datapath: operand capture, reduction state, result/done, accumulator,
    // and the wait-state timeout counter. Done is registered on the edge
    // that enters FINISH (or aborts) so it is visible during that cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lane_data <= '0;
            r_acc_mode  <= 1'b0;
            r_acc       <= '0;
            r_sum       <= '0;
            r_idx       <= '0;
            r_result    <= '0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_tmo       <= '0;
        end else begin
            r_sum  <= w_sum_nxt;
            r_idx  <= w_idx_nxt;
            r_done <= w_finish | w_abort;

            if (w_accept) begin
                r_lane_data <= i_data_in;
                r_acc_mode  <= i_acc_mode;
                r_result    <= '0;
                r_error     <= 1'b0;
            end
            if (w_finish) begin
                r_result <= w_sum_nxt;
                r_error  <= 1'b0;
            end
            if (w_abort) begin
                r_result <= NAN_WORD;
                r_error  <= 1'b1;
            end

            if ((r_state == IDLE) && i_acc_clear) begin
                r_acc <= '0;
            end else if ((r_state == FINISH) && r_acc_mode) begin
                r_acc <= r_sum;
            end

            if (w_waiting) begin
                r_tmo <= r_tmo + TMO_W'(1);
            end else begin
                r_tmo <= '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/cordic_reduce_seq.md
Name: cordic_reduce_seq

Overview:
- Multi-lane launch-and-reduce sequencer for the floating-point CORDIC datapath.
- Fans `start` out to NUM_LANES external CORDIC lane cores and collects each lane's result whenever that lane finishes; lanes may finish on different cycles.
- Then sums the lane results serially through one shared external FP adder using its enable/done handshake, and returns the sum with a one-cycle `done`.
- Optional accumulate mode adds every call's sum into a persistent accumulator; a timeout guard aborts hung lanes or adder.

Parameters:
- NUM_LANES, 4: number of CORDIC lanes (1..16).
- DATA_W, 32: IEEE-754 single word width.
- TIMEOUT_CYCLES, 1024: maximum cycles allowed in any wait state before abort.
- NAN_WORD, 32'h7FC0_0000: result driven on abort.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request; ignored unless IDLE.
- acc_mode  in  1  sampled with start; 1 = add this call's sum into the accumulator.
- acc_clear  in  1  in IDLE, zeroes the accumulator; ignored otherwise.
- data_in  in  NUM_LANES*DATA_W  lane operands, lane i at [i*DATA_W +: DATA_W]; sampled with start.
- lane_data  out  NUM_LANES*DATA_W  registered operands to the lane cores.
- lane_start  out  NUM_LANES  one-cycle pulse, all bits together.
- lane_done  in  NUM_LANES  per-lane completion pulse.
- lane_result  in  NUM_LANES*DATA_W  lane results; valid while the matching lane_done bit is high.
- add_dataa  out  DATA_W  adder operand A (running sum).
- add_datab  out  DATA_W  adder operand B (next lane value).
- add_enable  out  1  one-cycle adder request.
- add_done  in  1  adder completion pulse; add_result valid in that cycle.
- add_result  in  DATA_W  adder output.
- result  out  DATA_W  final sum; held until the next accepted start.
- done  out  1  one-cycle completion pulse.
- error  out  1  with done: 1 = timeout abort; held until the next accepted start.
- busy  out  1  high whenever the FSM is not IDLE.

Behaviour:
- Reset (async, rst_n low): FSM to IDLE; every output, lane register, done mask, accumulator and counter to 0. Reset mid-operation discards the operation with no done pulse.
- IDLE:
  - start=1 registers data_in into lane_data, latches acc_mode, clears the done mask and sets busy. Next state LAUNCH.
  - acc_clear=1 with no start zeroes the accumulator.
  - start and acc_clear together: the clear applies first, then the start is accepted.
- LAUNCH (1 cycle): lane_start = all ones. Next state WAIT_LANES.
- WAIT_LANES:
  - For each lane_done[i] with mask[i]=0: capture lane_result[i] into slot i and set mask[i].
  - Repeat pulses from an already-done lane are ignored. Several lanes may finish in the same cycle.
  - When the mask is all ones, go to REDUCE_INIT.
  - A lane_done pulse in any other state is ignored.
- REDUCE_INIT (1 cycle): set sum and index as follows.
  - acc_mode=0: sum = slot0, idx = 1.
  - acc_mode=1: sum = accumulator, idx = 0.
  - If idx equals NUM_LANES, go to FINISH; otherwise go to ADD_ISSUE.
- ADD_ISSUE (1 cycle): add_dataa = sum, add_datab = slot[idx], add_enable = 1. Next state ADD_WAIT. add_dataa and add_datab stay stable until add_done.
- ADD_WAIT:
  - On add_done: sum = add_result, idx increments.
  - If idx now equals NUM_LANES, go to FINISH; else go to ADD_ISSUE.
  - add_done outside ADD_WAIT is ignored.
- FINISH (1 cycle): result = sum, done = 1, error = 0. If acc_mode=1, accumulator = sum. Next state IDLE with busy low.
- Timeout:
  - The counter resets on entry to WAIT_LANES and to ADD_WAIT.
  - If TIMEOUT_CYCLES elapse without completion: result = NAN_WORD, error = 1, done pulse, accumulator unchanged, go to IDLE.
  - Late lane_done or add_done pulses after an abort are ignored.
- Latency: start at cycle 0 gives lane_start at cycle 1. Done arrives 1 cycle after the last add_done, or 2 cycles after the last lane_done when no add is needed (NUM_LANES=1 with acc_mode=0).
- Number of adds: NUM_LANES-1 with acc_mode=0, NUM_LANES with acc_mode=1.
- The block performs no arithmetic itself; FP semantics belong to the adder.

Decomposition:
- Package cordic_pkg holds:
  - the state enum (IDLE, LAUNCH, WAIT_LANES, REDUCE_INIT, ADD_ISSUE, ADD_WAIT, FINISH);
  - FP constants FP_ZERO=32'h0 and FP_QNAN=32'h7FC0_0000;
  - the DATA_W default.
- One natural sub-module, lane_collect: the done mask, per-lane capture registers and the all-done flag.
- The FSM, reduction and timeout stay in the top level.

Test Plan:
- NUM_LANES=4, acc_mode=0, inputs fed to lane models that return 1.0/2.0/3.0/4.0 (3F800000/40000000/40400000/40800000), lane_done pulses at cycles 5/9/3/7, adder model with 3-cycle latency -> exactly 3 add_enable pulses, result=41200000 (10.0), error=0, done pulsed once.
- Same stimulus run twice with acc_mode=1 after acc_clear -> 4 adds per call, results 41200000 then 41A00000 (20.0).
- Lane 2 never asserts lane_done, TIMEOUT_CYCLES=64 -> done and error both 1 at 64 cycles into WAIT_LANES, result=7FC00000, accumulator unchanged, next call succeeds.
- Duplicate lane_done on lane 0, start asserted mid-run, add_done pulsed in IDLE -> all ignored, sum still 41200000.
- All four lane_done bits in the same cycle -> REDUCE_INIT on the next cycle, correct sum.
- rst_n low during ADD_WAIT -> all outputs 0 immediately, no done pulse; a fresh start then completes normally.
